led_sched: RTL
==============

# led_sched

Round-robin scheduler that shares the 8-LED bank among `NREQ` independent requesters. Each requester submits a display job: pattern, duration in quarter-second ticks, and a steady/blink flag. The block grants one job at a time and times it with an internal prescaler. It sits between the status/debug sources and the board LEDs, and replaces direct ad-hoc LED drivers.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `TICK_DIV`, default CLK_FREQ/4: clock cycles per tick. Must be ≥ 2. Set small in simulation.
- `NREQ`, default 4: number of requesters, 2..8.
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, NREQ: job offered by requester i.
- `req_pattern`, in, 8*NREQ: LED pattern. Requester i uses bits [8i+7:8i].
- `req_ticks`, in, 4*NREQ: duration in ticks. 0 is treated as 1.
- `req_blink`, in, NREQ: 1 means the pattern alternates with all-off on every tick.
- `req_ready`, out, NREQ: one-hot accept. This output is combinational.
- `leds`, out, 8: registered LED drive.
- `busy`, out, 1: high while a job is displayed.
- `grant_id`, out, 3: index of the current or last granted requester.

## Operation
- FSM has two states: IDLE and SHOW.
- **IDLE**
  - `req_ready` = one-hot round-robin winner among `req_valid`. Search starts at `last_grant+1` and wraps modulo NREQ.
  - A handshake occurs when `req_valid[i]` and `req_ready[i]` are both high at a clock edge. On that edge:
    - latch the pattern, blink flag and `max(ticks,1)` as `remaining`;
    - clear the prescaler and the blink phase;
    - set `leds` to the pattern;
    - set `last_grant` and `grant_id` to i;
    - go to SHOW.
- **SHOW**
  - `req_ready` is all zeros.
  - The prescaler counts 0..TICK_DIV-1. A tick is the edge where the count equals TICK_DIV-1; the count then wraps to 0.
  - On a non-final tick:
    - `remaining` decrements;
    - if blink is set, the phase toggles and `leds` = phase ? 8'h00 : pattern;
    - with blink clear, `leds` stays at the pattern.
  - On the final tick (`remaining`==1): `leds` goes to 8'h00 and the FSM returns to IDLE.
- Inputs are ignored in SHOW, so requester inputs may change freely there. A requester holds its inputs stable only while its `req_valid` is high in IDLE.
- A requester that drops `req_valid` before being granted loses nothing; no request state is stored.

## Timing
- Reset (asynchronous, takes effect immediately):
  - outputs: `leds`=8'h00, `busy`=0, `grant_id`=NREQ-1, `req_ready`=0;
  - internal: state IDLE, `last_grant`=NREQ-1, so requester 0 has top priority first.
- A job with duration T ticks drives non-zero-phase LEDs for exactly T*TICK_DIV cycles, counted from the handshake edge.
- Gap between jobs: at least 1 cycle of IDLE with `leds`=0. The earliest next handshake is the first edge after the return to IDLE.
- `busy` is registered: it goes to 1 on the handshake edge and to 0 on the final-tick edge.
- Simultaneous valids: exactly one grant per IDLE cycle, in rotating order. No requester waits more than NREQ-1 jobs.
- Counter widths:
  - prescaler is $clog2(TICK_DIV) bits;
  - `remaining` is 4 bits;
  - no overflow is possible.
- Reset asserted mid-SHOW: `leds` clears immediately, with no clock edge needed. The job is lost.

## Structure
- Shared package/header `led_sched_pkg` holds:
  - state encodings S_IDLE and S_SHOW;
  - the tick-width constant (4);
  - the LED width (8);
  - OFF_PATTERN = 8'h00.
- One natural sub-module, `rr_arbiter`: parameterized on NREQ, combinational one-hot grant from the request vector and a `last_grant` input. The pointer register stays in `led_sched`.

## Test plan
All scenarios use TICK_DIV=4 and NREQ=4.
- **Reset:** hold `rst_n`=0 with random inputs.
  - `leds`=0, `busy`=0, `req_ready`=0, `grant_id`=3.
- **Single steady job:** req1 with pattern 8'hA5, ticks=3, blink=0.
  - `req_ready`=4'b0010 for 1 cycle.
  - `leds`=8'hA5 for 12 cycles, then 8'h00.
  - `busy` is high for those 12 cycles.
- **Blink job:** req2 with pattern 8'h81, ticks=4, blink=1.
  - `leds` sequence is 81, 00, 81, 00, each held 4 cycles, then 00.
- **Round robin:** all four valid continuously, ticks=1.
  - Grant order 0,1,2,3,0.
  - Each job is 4 cycles followed by a 1-cycle gap.
- **Zero duration:** req3 with ticks=0.
  - Pattern is shown for 4 cycles.
- **Async reset mid-SHOW:** assert `rst_n` low in the 2nd tick of a job.
  - `leds`=0 before the next edge.
  - After release, with req0 and req3 both valid, req0 is granted.

Source files
------------

// File: rtl/led_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_sched_pkg: state encodings, widths and helpers shared by the LED scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
package led_sched_pkg;

  localparam int TICKS_W = 4;
  localparam int LED_W   = 8;

  localparam logic [LED_W-1:0] OFF_PATTERN = 8'h00;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  // A zero duration still shows the pattern for one tick.
  function automatic logic [TICKS_W-1:0] clamp_ticks(input logic [TICKS_W-1:0] t);
    return (t == '0) ? TICKS_W'(1) : t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: combinational one-hot round-robin grant, search starts after last_grant
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_grant,
  output logic [NREQ-1:0] grant
);

  logic [3:0] w_idx;
  logic       w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, last_grant} + 4'(k);
      if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (w_idx == 4'(i)) && req[i]) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_sched: round-robin sharing of the LED bank among NREQ timed display jobs
// Revision: 1.0
// ----------------------------------------------------------------------------
module led_sched
  import led_sched_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_DIV = CLK_FREQ / 4,
  parameter int NREQ     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [LED_W*NREQ-1:0]   req_pattern,
  input  logic [TICKS_W*NREQ-1:0] req_ticks,
  input  logic [NREQ-1:0]         req_blink,
  output logic [NREQ-1:0]         req_ready,
  output logic [LED_W-1:0]        leds,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  localparam int            PW          = $clog2(TICK_DIV);
  localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);

  logic [0:0]         r_state, w_state_nxt;
  logic [PW-1:0]      r_pre, w_pre_nxt;
  logic [TICKS_W-1:0] r_remaining, w_remaining_nxt;
  logic [LED_W-1:0]   r_pattern, w_pattern_nxt;
  logic               r_blink, w_blink_nxt;
  logic               r_phase, w_phase_nxt;
  logic [LED_W-1:0]   r_leds, w_leds_nxt;
  logic               r_busy, w_busy_nxt;
  logic [2:0]         r_last_grant, w_last_grant_nxt;

  logic [NREQ-1:0]    w_grant;
  logic               w_hs;
  logic               w_tick;
  logic               w_final;
  logic [2:0]         w_sel;
  logic [LED_W-1:0]   w_sel_pattern;
  logic [TICKS_W-1:0] w_sel_ticks;
  logic               w_sel_blink;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Select the winning requester's job fields from the one-hot grant.
  always_comb begin
    w_sel         = '0;
    w_sel_pattern = OFF_PATTERN;
    w_sel_ticks   = '0;
    w_sel_blink   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel         = 3'(i);
        w_sel_pattern = req_pattern[LED_W*i +: LED_W];
        w_sel_ticks   = req_ticks[TICKS_W*i +: TICKS_W];
        w_sel_blink   = req_blink[i];
      end
    end
  end

  assign w_hs    = |(req_valid & req_ready);
  assign w_tick  = (r_state == S_SHOW) && (r_pre == C_TICK_LAST);
  assign w_final = w_tick && (r_remaining == TICKS_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)    w_state_nxt = S_SHOW;
      S_SHOW:  if (w_final) w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is masked during reset so no grant is offered while rst_n is low.
  always_comb begin
    req_ready        = (r_state == S_IDLE && rst_n) ? w_grant : '0;
    w_pre_nxt        = r_pre;
    w_remaining_nxt  = r_remaining;
    w_pattern_nxt    = r_pattern;
    w_blink_nxt      = r_blink;
    w_phase_nxt      = r_phase;
    w_leds_nxt       = r_leds;
    w_busy_nxt       = r_busy;
    w_last_grant_nxt = r_last_grant;
    if (r_state == S_IDLE) begin
      if (w_hs) begin
        w_pattern_nxt    = w_sel_pattern;
        w_blink_nxt      = w_sel_blink;
        w_remaining_nxt  = clamp_ticks(w_sel_ticks);
        w_pre_nxt        = '0;
        w_phase_nxt      = 1'b0;
        w_leds_nxt       = w_sel_pattern;
        w_busy_nxt       = 1'b1;
        w_last_grant_nxt = w_sel;
      end
    end else begin
      w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
      if (w_final) begin
        w_leds_nxt = OFF_PATTERN;
        w_busy_nxt = 1'b0;
      end else if (w_tick) begin
        w_remaining_nxt = r_remaining - TICKS_W'(1);
        if (r_blink) begin
          w_phase_nxt = ~r_phase;
          w_leds_nxt  = (~r_phase) ? OFF_PATTERN : r_pattern;
        end else begin
          w_leds_nxt  = r_pattern;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_remaining  <= '0;
      r_pattern    <= OFF_PATTERN;
      r_blink      <= 1'b0;
      r_phase      <= 1'b0;
      r_leds       <= OFF_PATTERN;
      r_busy       <= 1'b0;
      r_last_grant <= 3'(NREQ - 1);
    end else begin
      r_pre        <= w_pre_nxt;
      r_remaining  <= w_remaining_nxt;
      r_pattern    <= w_pattern_nxt;
      r_blink      <= w_blink_nxt;
      r_phase      <= w_phase_nxt;
      r_leds       <= w_leds_nxt;
      r_busy       <= w_busy_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  assign leds     = r_leds;
  assign busy     = r_busy;
  assign grant_id = r_last_grant;

endmodule
`default_nettype wire
